uart_tx_fifo_param: RTL and testbench

//  Parametrised next-generation UART transmitter: configurable data width, runtime parity mode
//  (none/even/odd) and stop-bit count, integer baud divisor, plus a small input FIFO with

---
 rtl/uart_tx_fifo_param.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with a small input FIFO, runtime parity/stop configuration and integer baud divisor.
// o_tx is registered one cycle behind the FSM, so a push into an idle block reaches the line two edges later.
module uart_tx_fifo_param #(
  parameter int BAUD_DIV   = 434,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [1:0]                    i_parity_mode,
  input  logic                          i_two_stop,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic [DATA_BITS-1:0] head;

  state_t               state;
  logic [BW-1:0]        bcnt;
  logic [IW-1:0]        bidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 par_en;
  logic                 two_stop;
  logic                 stop_idx;

  logic push;
  logic pop;
  logic bit_end;
  logic fifo_empty;
  logic frame_done;
  logic tx_next;

  assign head         = mem[rd_ptr];
  assign fifo_empty   = (count == '0);
  assign bit_end      = (bcnt == BW'(BAUD_DIV - 1));
  assign frame_done   = (state == STOP) && bit_end && (stop_idx || !two_stop);
  assign push         = i_valid && o_ready;
  // The FSM takes the next character either from IDLE or straight out of the last stop bit.
  assign pop          = !fifo_empty && ((state == IDLE) || frame_done);
  assign o_fifo_count = count;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg[0];
      PARITY:  tx_next = par_bit;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_next;
      o_ready <= (count_next != CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      bcnt     <= '0;
      bidx     <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      two_stop <= 1'b0;
      stop_idx <= 1'b0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      o_tx   <= tx_next;
      o_busy <= (state != IDLE) || !fifo_empty;

      if (state == IDLE || bit_end) bcnt <= '0;
      else                          bcnt <= bcnt + BW'(1);

      // Parity and stop configuration are captured with the character so mid-frame changes wait.
      if (pop) begin
        shreg    <= head;
        par_en   <= (i_parity_mode == 2'd1) || (i_parity_mode == 2'd2);
        par_bit  <= (i_parity_mode == 2'd2) ^ (^head);
        two_stop <= i_two_stop;
        stop_idx <= 1'b0;
        bidx     <= '0;
        state    <= START;
      end else begin
        case (state)
          START: begin
            if (bit_end) begin
              bidx  <= '0;
              state <= DATA;
            end
          end
          DATA: begin
            if (bit_end) begin
              shreg <= shreg >> 1;
              if (bidx == IW'(DATA_BITS - 1)) begin
                stop_idx <= 1'b0;
                state    <= par_en ? PARITY : STOP;
              end else begin
                bidx <= bidx + IW'(1);
              end
            end
          end
          PARITY: begin
            if (bit_end) begin
              stop_idx <= 1'b0;
              state    <= STOP;
            end
          end
          STOP: begin
            if (bit_end) begin
              if (two_stop && !stop_idx) stop_idx <= 1'b1;
              else                       state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench for uart_tx_fifo_param: accepted characters are queued with their line
// configuration and every serial sample of each frame is compared against a bit model.
module tb_uart_tx_fifo_param;

  localparam int B  = 4;
  localparam int DB = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DB-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [1:0]    i_parity_mode = 2'd0;
  logic          i_two_stop = 1'b0;
  logic          o_tx;
  logic          o_busy;
  logic [2:0]    o_fifo_count;

  uart_tx_fifo_param #(.BAUD_DIV(B), .DATA_BITS(DB), .FIFO_DEPTH(FD)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_parity_mode (i_parity_mode),
    .i_two_stop    (i_two_stop),
    .o_tx          (o_tx),
    .o_busy        (o_busy),
    .o_fifo_count  (o_fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] mode;
    logic       ts;
  } frame_t;

  frame_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(frame_t f, int b);
    if (b == 0) return 1'b0;
    if (b <= DB) return f.d[3'(b - 1)];
    if ((f.mode == 2'd1 || f.mode == 2'd2) && b == DB + 1)
      return (f.mode == 2'd1) ? ^f.d : ~^f.d;
    return 1'b1;
  endfunction

  int     mon_pos = -1;
  int     mon_start = 0;
  int     mon_nbits = 0;
  int     frames_seen = 0;
  logic   b2b = 1'b0;
  int     b2b_prev = -1;
  frame_t cur;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_pos = -1;
      end else begin
        if (mon_pos < 0 && o_tx === 1'b0) begin
          if (sb.size() == 0) begin
            chk("unexpected_start", 32'd1, 32'd0);
          end else begin
            cur = sb.pop_front();
            mon_pos = 0;
            mon_start = cyc;
            mon_nbits = 1 + DB + ((cur.mode == 2'd1 || cur.mode == 2'd2) ? 1 : 0) + (cur.ts ? 2 : 1);
            frames_seen++;
            if (b2b) begin
              if (b2b_prev >= 0) chk("b2b_gap", cyc - b2b_prev, 32'd40);
              b2b_prev = cyc;
            end
          end
        end
        if (mon_pos >= 0) begin
          chk("tx_bit", 32'(o_tx), 32'(exp_bit(cur, mon_pos / B)));
          mon_pos++;
          if (mon_pos == mon_nbits * B) mon_pos = -1;
        end
      end
    end
  end

  task automatic push_char(input logic [7:0] d, output int pcyc, output logic acc);
    frame_t f;
    @(negedge clk);
    i_data  = d;
    i_valid = 1'b1;
    acc     = o_ready;
    @(posedge clk);
    #1;
    pcyc = cyc;
    if (acc) begin
      f.d = d;
      f.mode = i_parity_mode;
      f.ts = i_two_stop;
      sb.push_back(f);
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int fall_cyc);
    int n;
    n = 0;
    fall_cyc = -1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (o_busy === 1'b0) begin
        fall_cyc = cyc;
        break;
      end
    end
    if (fall_cyc < 0) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pos(input int pos, input int budget);
    int n;
    n = 0;
    while (n < budget && mon_pos < pos) begin
      @(posedge clk);
      n++;
    end
    if (mon_pos < pos) chk("pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_one(input logic [7:0] d, input logic [1:0] mode, input logic ts, input int len);
    int   pc;
    int   fc;
    logic acc;
    i_parity_mode = mode;
    i_two_stop    = ts;
    push_char(d, pc, acc);
    chk("accepted", 32'(acc), 32'd1);
    @(negedge clk);
    chk("busy_before", 32'(o_busy), 32'd0);
    @(negedge clk);
    chk("busy_rise", 32'(o_busy), 32'd1);
    wait_idle(len * 2 + 20, fc);
    chk("latency", mon_start - pc, 32'd2);
    chk("frame_len", fc - mon_start, 32'(len));
    chk("sb_empty", sb.size(), 32'd0);
    chk("tx_idle", 32'(o_tx), 32'd1);
  endtask

  initial begin
    int   bad;
    int   pc;
    int   fc;
    int   n_acc;
    int   seen0;
    logic acc;
    logic [7:0] chars [6];
    chars[0] = 8'h11; chars[1] = 8'h22; chars[2] = 8'h33;
    chars[3] = 8'h44; chars[4] = 8'h55; chars[5] = 8'h66;

    // Reset state and quiet idle line.
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(o_tx), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_count", 32'(o_fifo_count), 32'd0);
    rst = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_fifo_count !== 3'd0) bad++;
    end
    chk("idle_hold", bad, 32'd0);

    // Single frames: no parity, parity even/odd, parity mode 3, two stop bits.
    send_one(8'hA5, 2'd0, 1'b0, 40);
    send_one(8'h07, 2'd1, 1'b1, 48);
    send_one(8'h07, 2'd2, 1'b1, 48);
    send_one(8'h5A, 2'd3, 1'b0, 40);
    send_one(8'h80, 2'd1, 1'b0, 44);

    // Back-to-back burst with valid held through a full FIFO.
    i_parity_mode = 2'd0;
    i_two_stop    = 1'b0;
    b2b      = 1'b1;
    b2b_prev = -1;
    n_acc    = 0;
    seen0    = frames_seen;
    for (int k = 0; k < 6; k++) begin
      push_char(chars[k], pc, acc);
      if (acc) n_acc++;
    end
    @(negedge clk);
    chk("full_count", 32'(o_fifo_count), 32'd4);
    chk("full_ready", 32'(o_ready), 32'd0);
    chk("burst_accepted", n_acc, 32'd5);
    wait_idle(400, fc);
    chk("burst_frames", frames_seen - seen0, 32'd5);
    chk("burst_sb_empty", sb.size(), 32'd0);
    chk("burst_ready", 32'(o_ready), 32'd1);
    b2b = 1'b0;

    // Reset in the middle of a data bit with two characters still queued.
    for (int k = 0; k < 3; k++) push_char(chars[k], pc, acc);
    wait_pos(3 * B, 100);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_tx", 32'(o_tx), 32'd1);
    chk("mid_rst_count", 32'(o_fifo_count), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    rst = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    chk("post_rst_quiet", bad, 32'd0);

    // Configuration change in flight: first frame keeps even parity, next uses odd + two stops.
    i_parity_mode = 2'd1;
    i_two_stop    = 1'b0;
    seen0 = frames_seen;
    push_char(8'h3C, pc, acc);
    wait_pos(2 * B, 100);
    i_parity_mode = 2'd2;
    i_two_stop    = 1'b1;
    push_char(8'h3C, pc, acc);
    wait_idle(300, fc);
    chk("cfg_frames", frames_seen - seen0, 32'd2);
    chk("cfg_second_len", fc - mon_start, 32'd48);
    chk("cfg_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
